stopwatch_key_ctrl: RTL and testbench

STOPWATCH_KEY_CTRL -- requirements
Module: stopwatch_key_ctrl

---
 rtl/stopwatch_key_ctrl.sv | 134 +++++++++++++
 tb/tb_stopwatch_key_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_key_ctrl.sv
// Stopwatch key controller: synchronizes and debounces start/lap/clear keys and runs the IDLE/RUN/LAP/STOP FSM.
// Latency: a held key changes state/outputs DB_CYCLES+3 rising edges after the raw key rises.
// Backpressure: none; key presses are one-cycle events, and events that lose priority in their cycle are dropped.
// Optional feature: define KEY_LONG_CLEAR_EN to enable long-clear (lap held HOLD_CYCLES cycles in STOP).
`timescale 1ns/1ps
module stopwatch_key_ctrl #(
  parameter int DB_CYCLES   = 3,
  parameter int HOLD_CYCLES = 100
) (
  input  logic clk_100hz,
  input  logic rst_n,
  input  logic key_start,
  input  logic key_lap,
  input  logic key_clr,
  output logic sw_en,
  output logic pause,
  output logic clear
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

  // Reject parameter values the 4-bit debounce and 7-bit hold counters cannot represent
  if (DB_CYCLES < 1 || DB_CYCLES > 15 || HOLD_CYCLES < 1 || HOLD_CYCLES > 127) begin : g_param_check
    $error("stopwatch_key_ctrl: DB_CYCLES must be 1..15 and HOLD_CYCLES 1..127");
  end

  // Key vector order: [0] start, [1] lap, [2] clear
  logic [2:0] raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] db;
  logic [2:0] evt;
  logic [3:0] cnt [3];

  assign raw = {key_clr, key_lap, key_start};

  // Two-flop synchronizers, then per-key debounce counter; a press event fires on the edge db rises
  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      evt   <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        evt[i] <= 1'b0;
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
          evt[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 4'd1;
        end
      end
    end
  end

  state_t state;
  state_t state_nxt;
  logic   clear_nxt;
  logic   long_clr;

`ifdef KEY_LONG_CLEAR_EN
  localparam logic [6:0] HOLD_LAST = 7'(HOLD_CYCLES - 1);
  logic [6:0] hold_cnt;
  logic [6:0] hold_nxt;
`endif

  // Next-state logic: clear (key or long hold) beats start, start beats lap
  always_comb begin
    state_nxt = state;
    clear_nxt = 1'b0;
    long_clr  = 1'b0;
`ifdef KEY_LONG_CLEAR_EN
    hold_nxt  = '0;
    if (state == STOP && db[1]) begin
      if (hold_cnt == HOLD_LAST) long_clr = 1'b1;
      else                       hold_nxt = hold_cnt + 7'd1;
    end
`endif
    if (evt[2] || long_clr) begin
      state_nxt = IDLE;
      // a clear pulse is never stretched into a second cycle
      clear_nxt = ~clear;
    end else if (evt[0]) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = STOP;
        LAP:     state_nxt = STOP;
        STOP:    state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end else if (evt[1]) begin
      case (state)
        RUN:     state_nxt = LAP;
        LAP:     state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
`ifdef KEY_LONG_CLEAR_EN
    if (state_nxt != STOP) hold_nxt = '0;
`endif
  end

  // State register and registered clear pulse
  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      clear <= 1'b0;
    end else begin
      state <= state_nxt;
      clear <= clear_nxt;
    end
  end

`ifdef KEY_LONG_CLEAR_EN
  // Consecutive-cycle count of lap held while stopped
  always_ff @(posedge clk_100hz or negedge rst_n) begin
    if (!rst_n) hold_cnt <= '0;
    else        hold_cnt <= hold_nxt;
  end
`endif

  assign sw_en = (state == RUN) || (state == LAP);
  assign pause = (state == LAP);

endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// Testbench for stopwatch_key_ctrl: directed scenarios plus random key activity against a window-based model.
// Latency: model predicts outputs each cycle from raw key history.
// Backpressure: not applicable.
`timescale 1ns/1ps
module tb_stopwatch_key_ctrl;

  localparam int DB   = 3;
  localparam int HOLD = 100;
  localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_STOP = 3;

  logic clk_100hz;
  logic rst_n;
  logic key_start, key_lap, key_clr;
  logic sw_en, pause, clear;

  stopwatch_key_ctrl #(.DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
    .clk_100hz(clk_100hz),
    .rst_n    (rst_n),
    .key_start(key_start),
    .key_lap  (key_lap),
    .key_clr  (key_clr),
    .sw_en    (sw_en),
    .pause    (pause),
    .clear    (clear)
  );

  initial clk_100hz = 1'b0;
  always #5 clk_100hz = ~clk_100hz;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: raw samples per key (index 0 = this edge), debounced levels, pending press events, stopwatch mode
  bit hist [3][18];
  bit mdb  [3];
  bit pend [3];
  int mst;
  bit mclr;
  int mhold;

  task automatic check(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0b, expected %0b", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 18; j++) hist[k][j] = 1'b0;
      mdb[k]  = 1'b0;
      pend[k] = 1'b0;
    end
    mst   = S_IDLE;
    mclr  = 1'b0;
    mhold = 0;
  endtask

  task automatic model_step();
    bit       fire;
    bit       flip;
    bit [2:0] raw_now;
    fire = 1'b0;
`ifdef KEY_LONG_CLEAR_EN
    if (mst == S_STOP && mdb[1]) begin
      mhold++;
      if (mhold >= HOLD) fire = 1'b1;
    end else begin
      mhold = 0;
    end
`endif
    if (pend[2] || fire) begin
      mst  = S_IDLE;
      mclr = !mclr;
    end else begin
      mclr = 1'b0;
      if (pend[0]) begin
        if (mst == S_IDLE || mst == S_STOP) mst = S_RUN;
        else                                mst = S_STOP;
      end else if (pend[1]) begin
        if (mst == S_RUN)      mst = S_LAP;
        else if (mst == S_LAP) mst = S_RUN;
      end
    end
    if (fire || mst != S_STOP) mhold = 0;
    // A key's debounced level flips when its DB samples, seen two edges late, all differ from it
    raw_now = {key_clr, key_lap, key_start};
    for (int k = 0; k < 3; k++) begin
      for (int j = 17; j > 0; j--) hist[k][j] = hist[k][j-1];
      hist[k][0] = raw_now[k];
      flip = 1'b1;
      for (int j = 2; j <= DB + 1; j++) if (hist[k][j] == mdb[k]) flip = 1'b0;
      pend[k] = 1'b0;
      if (flip) begin
        mdb[k]  = !mdb[k];
        pend[k] = mdb[k];
      end
    end
  endtask

  // One clock: model advances on the edge, DUT compared 1 ns later; caller drives inputs afterwards
  task automatic cycle();
    @(posedge clk_100hz);
    cyc++;
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    check("sw_en", sw_en, (mst == S_RUN || mst == S_LAP));
    check("pause", pause, (mst == S_LAP));
    check("clear", clear, mclr);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_start();
    key_start = 1'b1; run(6); key_start = 1'b0; run(8);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check("async_rst_sw_en", sw_en, 1'b0);
    check("async_rst_pause", pause, 1'b0);
    check("async_rst_clear", clear, 1'b0);
    model_reset();
    cycle();
    rst_n = 1'b1;
  endtask

  int clr_cnt;
  int clr_at;

  initial begin
    rst_n = 1'b0; key_start = 1'b0; key_lap = 1'b0; key_clr = 1'b0;
    model_reset();
    #2;
    check("reset_sw_en", sw_en, 1'b0);
    check("reset_pause", pause, 1'b0);
    check("reset_clear", clear, 1'b0);
    run(3);
    rst_n = 1'b1;
    run(2);

    // start held 10 cycles: RUN exactly at edge 6
    key_start = 1'b1;
    run(5);
    check("start_edge5_sw_en", sw_en, 1'b0);
    cycle();
    check("start_edge6_sw_en", sw_en, 1'b1);
    check("start_edge6_pause", pause, 1'b0);
    run(4); key_start = 1'b0; run(8);

    // lap glitch of 2 cycles ignored, 5-cycle lap enters LAP, next lap returns to RUN
    key_lap = 1'b1; run(2); key_lap = 1'b0; run(8);
    check("lap_glitch_pause", pause, 1'b0);
    check("lap_glitch_sw_en", sw_en, 1'b1);
    key_lap = 1'b1; run(5); key_lap = 1'b0; cycle();
    check("lap_press_pause", pause, 1'b1);
    check("lap_press_sw_en", sw_en, 1'b1);
    run(8);
    key_lap = 1'b1; run(6);
    check("lap_resume_pause", pause, 1'b0);
    key_lap = 1'b0; run(8);
    key_lap = 1'b1; run(6); key_lap = 1'b0; run(8);

    // start from LAP stops, start again runs
    key_start = 1'b1; run(6);
    check("lap_start_sw_en", sw_en, 1'b0);
    check("lap_start_pause", pause, 1'b0);
    key_start = 1'b0; run(8);
    key_start = 1'b1; run(6);
    check("stop_start_sw_en", sw_en, 1'b1);
    key_start = 1'b0; run(8);

    // clear and start together in RUN: clear wins, one-cycle pulse
    key_clr = 1'b1; key_start = 1'b1; run(6);
    check("clr_pulse", clear, 1'b1);
    check("clr_sw_en", sw_en, 1'b0);
    cycle();
    check("clr_pulse_end", clear, 1'b0);
    run(5); key_clr = 1'b0; key_start = 1'b0; run(8);

    // reset mid-RUN: outputs drop at once, nothing happens without a new press
    press_start();
    check("run_before_rst", sw_en, 1'b1);
    async_reset();
    run(20);
    check("after_rst_idle", sw_en, 1'b0);

    // key held across reset counts as a new press after release
    key_start = 1'b1; run(3);
    async_reset();
    run(5);
    check("held_rst_edge5", sw_en, 1'b0);
    cycle();
    check("held_rst_edge6", sw_en, 1'b1);
    key_start = 1'b0; run(8);

`ifdef KEY_LONG_CLEAR_EN
    // long clear: RUN -> STOP, lap held 110 cycles gives exactly one clear on hold count 100
    press_start();
    clr_cnt = 0; clr_at = 0;
    key_lap = 1'b1;
    for (int i = 1; i <= 110; i++) begin
      cycle();
      if (clear) begin clr_cnt++; clr_at = i; end
    end
    key_lap = 1'b0; run(8);
    check("long_clr_once", (clr_cnt == 1), 1'b1);
    check("long_clr_edge105", (clr_at == 105), 1'b1);
    check("long_clr_idle", sw_en, 1'b0);
    press_start(); press_start();
    clr_cnt = 0;
    key_lap = 1'b1;
    for (int i = 0; i < 50; i++) begin cycle(); if (clear) clr_cnt++; end
    key_lap = 1'b0;
    for (int i = 0; i < 60; i++) begin cycle(); if (clear) clr_cnt++; end
    check("short_hold_no_clr", (clr_cnt == 0), 1'b1);
    key_start = 1'b1; run(6);
    check("short_hold_still_stop", sw_en, 1'b1);
    key_start = 1'b0; run(8);
`endif

    // random key activity with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) key_start = ~key_start;
      if ($urandom_range(0, 5) == 0) key_lap   = ~key_lap;
      if (key_clr) begin
        if ($urandom_range(0, 2) == 0) key_clr = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        key_clr = 1'b1;
      end
      if ($urandom_range(0, 799) == 0) async_reset();
      else                             cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
